// File: rtl/seq11_fsm_pkg.sv
// Shared state definitions for the two-consecutive-ones detector and
// other control FSMs built on the same pattern.
package seq11_fsm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        STATE_IDLE   = 2'b00,
        STATE_S0     = 2'b01,
        STATE_S1     = 2'b10,
        STATE_UNUSED = 2'b11
    } state_e;

    // Detect flag is high only in S1; the unused code decodes as inactive.
    function automatic logic state_is_detect(input state_e s);
        return (s == STATE_S1);
    endfunction

endpackage

// File: rtl/seq11_fsm.sv
// Moore FSM that flags two or more consecutive 1s on a serial input.
// The output depends only on the state register, so it never glitches with in.
module seq11_fsm
    import seq11_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    state_e state_r;
    state_e next_state_s;

    // State register with asynchronous active-low reset to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= STATE_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; an unknown in takes the in=0 path back to IDLE.
    always_comb begin
        next_state_s = STATE_IDLE;
        case (state_r)
            STATE_IDLE: begin
                if (in) begin
                    next_state_s = STATE_S0;
                end else begin
                    next_state_s = STATE_IDLE;
                end
            end
            STATE_S0: begin
                if (in) begin
                    next_state_s = STATE_S1;
                end else begin
                    next_state_s = STATE_IDLE;
                end
            end
            STATE_S1: begin
                if (in) begin
                    next_state_s = STATE_S1;
                end else begin
                    next_state_s = STATE_IDLE;
                end
            end
            default: begin
                // Unused code recovers exactly like IDLE.
                if (in) begin
                    next_state_s = STATE_S0;
                end else begin
                    next_state_s = STATE_IDLE;
                end
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        out = 1'b0;
        out = state_is_detect(state_r);
    end

endmodule

// File: tb/tb_seq11_fsm.sv
// Self-checking bench for seq11_fsm: a run-length reference model pushes the
// expected out/state per edge into a queue, which each scenario pops and checks.
module tb_seq11_fsm;

    typedef struct packed {
        logic       o;
        logic [1:0] st;
    } exp_t;

    logic clk;
    logic rst;
    logic in;
    logic out;

    int   n_checks;
    int   n_fail;
    int   run_len;
    exp_t sb_q[$];

    seq11_fsm dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit for the next rising edge, update the run-length model,
    // push the expected result, and return 1 time unit after that edge.
    task automatic drive_bit(input logic b);
        exp_t e;
        in = b;
        if (b === 1'b1) begin
            run_len = run_len + 1;
        end else begin
            run_len = 0;
        end
        e.o  = (run_len >= 2);
        e.st = (run_len == 0) ? 2'b00 : ((run_len == 1) ? 2'b01 : 2'b10);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] st;
        rst = 1'b0;
        in  = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            st = dut.state_r;
            n_checks++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold_out edge %0d: got %b want 0", i, out);
            end
            n_checks++;
            if (st !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold_state edge %0d: got %b want 00", i, st);
            end
        end
        @(negedge clk);
        rst     = 1'b1;
        run_len = 0;
    endtask

    task automatic test_seq(input string name, input logic [15:0] bits, input int len);
        exp_t       e;
        logic [1:0] st;
        for (int i = 0; i < len; i++) begin
            drive_bit(bits[len-1-i]);
            e  = sb_q.pop_front();
            st = dut.state_r;
            n_checks++;
            if (out !== e.o) begin
                n_fail++;
                $display("FAIL %s_out step %0d: got %b want %b", name, i, out, e.o);
            end
            n_checks++;
            if (st !== e.st) begin
                n_fail++;
                $display("FAIL %s_state step %0d: got %b want %b", name, i, st, e.st);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [1:0] st;
        test_seq("pre_reset", 16'b11, 2);
        #2;
        rst = 1'b0;
        #1;
        st = dut.state_r;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_out: got %b want 0", out);
        end
        n_checks++;
        if (st !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_state: got %b want 00", st);
        end
        in = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_out: got %b want 0", out);
        end
        @(negedge clk);
        rst     = 1'b1;
        run_len = 0;
        test_seq("post_reset", 16'b110, 3);
    endtask

    task automatic test_toggle();
        logic [1:0] st;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in = 1'b1;
            #2 in = 1'b0;
            #1 in = 1'b1;
            #1 in = 1'b0;
            @(posedge clk);
            #1;
            in = 1'b1;
            st = dut.state_r;
            n_checks++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL toggle_out step %0d: got %b want 0", i, out);
            end
            n_checks++;
            if (st !== 2'b00) begin
                n_fail++;
                $display("FAIL toggle_state step %0d: got %b want 00", i, st);
            end
        end
        in      = 1'b0;
        run_len = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        run_len  = 0;
        rst      = 1'b0;
        in       = 1'b0;
        test_reset();
        test_seq("single_pulse", 16'b10, 2);
        test_seq("pair", 16'b110, 3);
        test_seq("long_run", 16'b11110, 5);
        test_seq("mixed", 16'b101100110, 9);
        test_midrun_reset();
        test_toggle();
        test_seq("back_to_back", 16'b1101101110, 10);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
